// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: shared UART constants, FSM encodings and baud divisor helper.
// Shared with the transmit path; OVERSAMPLE is fixed at 16.
package uart_byte_rx_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int VOTE_LO    = 6;
  localparam int VOTE_HI    = 10;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Encodings 5-7 fall back to the fastest rate.
  function automatic logic [15:0] baud_div(
    input int         clk_freq,
    input logic [2:0] sel
  );
    int baud;
    case (sel)
      BAUD_9600:   baud = 9600;
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 115200;
    endcase
    return 16'(clk_freq / (baud * OVERSAMPLE));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversampling tick generator from a baud select code.
// Held at zero while clr is high; reusable by the transmit side.
module uart_baud_tick
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] baud_sel,
  output logic       tick
);

  logic [15:0] cnt;
  logic [15:0] div;

  assign div  = baud_div(CLK_FREQ, baud_sel);
  assign tick = !clr && (cnt == div - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, 16x oversampled with 5-sample majority vote.
// Define UART_RX_PARITY_EN for 8E1 framing and the Parity_Err strobe.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  input  logic [2:0] Baud_Set,
  output logic [7:0] Data,
  output logic       Rx_Done,
  output logic       Frame_Err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       Parity_Err
`endif
);

  logic       rx_s1;
  logic       rx_s2;
  logic       rx_s3;
  logic       fall;
  logic [2:0] state;
  logic [2:0] baud_q;
  logic       idle;
  logic       tick;
  logic [3:0] s_cnt;
  logic [2:0] ones;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic       vote;
  logic       in_win;
  logic       at_vote;
  logic       at_end;
`ifdef UART_RX_PARITY_EN
  logic       par_bad;
`endif

  assign fall    = rx_s3 & ~rx_s2;
  assign idle    = (state == ST_IDLE);
  assign in_win  = (s_cnt >= 4'(VOTE_LO)) &&
                   (s_cnt <= 4'(VOTE_HI));
  assign at_vote = tick && (s_cnt == 4'(VOTE_HI));
  assign at_end  = tick && (s_cnt == 4'(OVERSAMPLE - 1));
  // Samples 6..9 are in ones; sample 10 is the live line.
  assign vote    = (ones + {2'b00, rx_s2}) >= 3'd3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .clr      (idle),
    .baud_sel (baud_q),
    .tick     (tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      baud_q    <= '0;
      s_cnt     <= '0;
      ones      <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      Data      <= '0;
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      Parity_Err <= 1'b0;
`endif
    end else begin
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_Err <= 1'b0;
`endif
      if (tick) begin
        s_cnt <= s_cnt + 4'd1;
        if (at_end) begin
          ones <= '0;
        end else if (in_win && rx_s2) begin
          ones <= ones + 3'd1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_START;
            baud_q  <= Baud_Set;
            s_cnt   <= '0;
            ones    <= '0;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state <= ST_IDLE;
          end else if (at_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_vote) begin
            sh <= {vote, sh[7:1]};
          end
          if (at_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (at_vote) begin
            par_bad <= vote ^ (^sh);
          end
          if (at_end) begin
            state <= ST_STOP;
          end
        end
`endif
        // Leave at mid stop bit so an immediately following start edge is seen.
        ST_STOP: begin
          if (at_vote) begin
            state     <= ST_IDLE;
            Frame_Err <= ~vote;
`ifdef UART_RX_PARITY_EN
            Rx_Done    <= vote & ~par_bad;
            Parity_Err <= vote & par_bad;
            if (vote && !par_bad) begin
              Data <= sh;
            end
`else
            Rx_Done <= vote;
            if (vote) begin
              Data <= sh;
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: serial line model drives uart_byte_rx; a queue scoreboard
// is filled by the stimulus and drained by a strobe monitor.
`timescale 1ns/1ps
module tb_uart_byte_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  logic       Clk;
  logic       Reset_n;
  logic       uart_rx;
  logic [2:0] Baud_Set;
  logic [7:0] Data;
  logic       Rx_Done;
  logic       Frame_Err;
  logic       perr;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Err;
  assign perr = Parity_Err;
`else
  assign perr = 1'b0;
`endif

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t    q[$];
  int      vectors = 0;
  int      errs    = 0;
  realtime t_start = 0;
  realtime t_strobe = 0;

  uart_byte_rx dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .uart_rx   (uart_rx),
    .Baud_Set  (Baud_Set),
    .Data      (Data),
    .Rx_Done   (Rx_Done),
`ifdef UART_RX_PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .Frame_Err (Frame_Err)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Rx_Done || Frame_Err || perr) begin
      int   k;
      exp_t e;
      k = Rx_Done ? K_DONE : (Frame_Err ? K_FERR : K_PERR);
      t_strobe = $realtime;
      vectors++;
      if (!$onehot({Rx_Done, Frame_Err, perr})) begin
        $display("FAIL strobe_excl: done=%b ferr=%b perr=%b want one",
                 Rx_Done, Frame_Err, perr);
        errs++;
      end
      if (q.size() == 0) begin
        $display("FAIL unexpected_strobe: kind=%0d data=%02h want none",
                 k, Data);
        errs++;
      end else begin
        e = q.pop_front();
        if (k != e.kind) begin
          $display("FAIL strobe_kind: got %0d want %0d", k, e.kind);
          errs++;
        end
        vectors++;
        if (Data !== e.data) begin
          $display("FAIL data: got %02h want %02h", Data, e.data);
          errs++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      $display("FAIL %s: got %0h want %0h", nm, act, want);
      errs++;
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    q.push_back(e);
  endtask

  function automatic real bit_ns(input int baud);
    return 1.0e9 / real'(baud);
  endfunction

  task automatic drive_bit(input logic v, input real ns);
    uart_rx = v;
    #(ns);
  endtask

  task automatic send_byte(input logic [7:0] b, input real ns,
                           input logic stop_v, input logic par_flip);
    t_start = $realtime;
    drive_bit(1'b0, ns);
    for (int i = 0; i < 8; i++) drive_bit(b[i], ns);
    if (PAR) drive_bit((^b) ^ par_flip, ns);
    drive_bit(stop_v, ns);
    uart_rx = 1'b1;
  endtask

  task automatic wait_drain(input int max_us);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_us) begin
      #1000;
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d pending want 0", q.size());
      errs++;
      q.delete();
    end
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1, "watchdog");
  end

  initial begin
    real b115;
    real b19;
    real lat;
    real lat_want;
    logic [7:0] v3c;

    b115     = bit_ns(115200);
    b19      = bit_ns(19200) * 1.02;
    v3c      = 8'h3C;
    uart_rx  = 1'b1;
    Baud_Set = 3'd4;
    Reset_n  = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("rst_data", 32'(Data), 32'h0);
    chk("rst_done", 32'(Rx_Done), 32'h0);
    chk("rst_ferr", 32'(Frame_Err), 32'h0);
    Reset_n = 1'b1;
    #2000;

    // 0x55 at 115200 with latency check
    expect_ev(K_DONE, 8'h55);
    send_byte(8'h55, b115, 1'b1, 1'b0);
    wait_drain(50);
    lat      = (t_strobe - t_start) / b115;
    lat_want = PAR ? 10.6 : 9.6;
    vectors++;
    if (lat < lat_want - 0.1 || lat > lat_want + 0.1) begin
      $display("FAIL latency: got %f bits want %f+-0.1", lat, lat_want);
      errs++;
    end
    #(b115);

    // stop bit forced low
    expect_ev(K_FERR, 8'h55);
    send_byte(8'hA3, b115, 1'b0, 1'b0);
    wait_drain(50);
    #(b115);

    // 1 us glitch at 9600, then a real frame
    Baud_Set = 3'd0;
    uart_rx  = 1'b0;
    #1000;
    uart_rx  = 1'b1;
    #80_000;
    Baud_Set = 3'd4;
    expect_ev(K_DONE, 8'hA3);
    send_byte(8'hA3, b115, 1'b1, 1'b0);
    wait_drain(50);
    #(b115);

    // back-to-back at 19200 with slow transmitter
    Baud_Set = 3'd1;
    expect_ev(K_DONE, 8'h00);
    expect_ev(K_DONE, 8'hFF);
    send_byte(8'h00, b19, 1'b1, 1'b0);
    send_byte(8'hFF, b19, 1'b1, 1'b0);
    wait_drain(100);
    #(b115);

    // reset in bit 4 of 0x3C; transmitter abandons frame
    Baud_Set = 3'd4;
    drive_bit(1'b0, b115);
    for (int i = 0; i < 4; i++) drive_bit(v3c[i], b115);
    uart_rx = v3c[4];
    #(b115 / 2.0);
    Reset_n = 1'b0;
    #1;
    chk("midrst_data", 32'(Data), 32'h0);
    chk("midrst_done", 32'(Rx_Done), 32'h0);
    chk("midrst_ferr", 32'(Frame_Err), 32'h0);
    #99;
    Reset_n = 1'b1;
    uart_rx = 1'b1;
    #(3.0 * b115);
    expect_ev(K_DONE, 8'h3C);
    send_byte(8'h3C, b115, 1'b1, 1'b0);
    wait_drain(50);
    #(b115);

`ifdef UART_RX_PARITY_EN
    expect_ev(K_PERR, 8'h3C);
    send_byte(8'h07, b115, 1'b1, 1'b1);
    wait_drain(50);
    #(b115);
    expect_ev(K_DONE, 8'h07);
    send_byte(8'h07, b115, 1'b1, 1'b0);
    wait_drain(50);
    #(b115);
`endif

    #(2.0 * b115);
    chk("queue_end", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
